memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_memory_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one memory command channel between a read-only fetch
// requester (I) and a load/store requester (D), with one read outstanding at most.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_start,
  input  logic [31:0] i_addr,
  output logic        i_cmd_ready,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic        d_cmd_ready,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic        mem_cmd_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  localparam logic [3:0]  LP_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [31:0] LP_ONES  = 32'hffff_ffff;
  localparam logic        OWN_I    = 1'b0;
  localparam logic        OWN_D    = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE        = 1'b0,
    ST_WAIT_RVALID = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic [3:0]  r_starve_cnt;

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_issue_ok;
  logic        w_i_acc;
  logic        w_d_acc;
  logic        w_d_read_acc;

  // Arbitration: D wins ties until I has been passed over STARVE_LIMIT times.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (i_cmd_start && d_cmd_start) begin
      if (r_starve_cnt >= LP_LIMIT) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_d = 1'b1;
      end
    end else if (i_cmd_start) begin
      w_grant_i = 1'b1;
    end else if (d_cmd_start) begin
      w_grant_d = 1'b1;
    end else begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  // rst_n gates issue so nothing leaks onto the memory bus while reset is held.
  assign w_issue_ok   = (r_state == ST_IDLE) && rst_n;
  assign w_i_acc      = w_issue_ok && w_grant_i && mem_cmd_ready;
  assign w_d_acc      = w_issue_ok && w_grant_d && mem_cmd_ready;
  assign w_d_read_acc = w_d_acc && !d_cmd_write;

  // Read data is broadcast; only the valid strobe is steered to the owner.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: reads park the FSM until their data returns.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_i_acc || w_d_read_acc) begin
          w_state_nxt = ST_WAIT_RVALID;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RVALID: begin
        if (mem_rdata_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_RVALID;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: command mux in IDLE, response steering in WAIT_RVALID.
  always_comb begin
    mem_cmd_start = 1'b0;
    mem_cmd_write = 1'b0;
    mem_addr      = LP_ONES;
    mem_wdata     = LP_ONES;
    mem_wmask     = LP_ONES;
    i_cmd_ready   = 1'b0;
    d_cmd_ready   = 1'b0;
    i_rdata_valid = 1'b0;
    d_rdata_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n) begin
          mem_cmd_start = i_cmd_start | d_cmd_start;
          i_cmd_ready   = w_grant_i & mem_cmd_ready;
          d_cmd_ready   = w_grant_d & mem_cmd_ready;
          if (w_grant_d) begin
            mem_cmd_write = d_cmd_write;
            mem_addr      = d_addr;
            mem_wdata     = d_wdata;
            mem_wmask     = d_wmask;
          end else if (w_grant_i) begin
            mem_addr      = i_addr;
          end else begin
            mem_addr      = LP_ONES;
          end
        end else begin
          mem_cmd_start = 1'b0;
        end
      end
      ST_WAIT_RVALID: begin
        if (mem_rdata_valid) begin
          i_rdata_valid = (r_owner == OWN_I);
          d_rdata_valid = (r_owner == OWN_D);
        end else begin
          i_rdata_valid = 1'b0;
          d_rdata_valid = 1'b0;
        end
      end
      default: begin
        mem_cmd_start = 1'b0;
      end
    endcase
  end

  // Owner of the outstanding read; writes never need a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_I;
    end else if (w_i_acc) begin
      r_owner <= OWN_I;
    end else if (w_d_read_acc) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= r_owner;
    end
  end

  // Starvation counter: D wins taken while I waits, loads and stores alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_i_acc) begin
      r_starve_cnt <= 4'd0;
    end else if (w_d_acc && i_cmd_start && (r_starve_cnt < LP_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios plus a randomized
// run checked against an independent arbitration and memory model.
module tb_memory_arbiter;

  localparam int LIMIT = 4;
  localparam logic [31:0] ONES = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_start;
  logic [31:0] i_addr;
  logic        i_cmd_ready;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;
  logic        d_cmd_start;
  logic        d_cmd_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_wmask;
  logic        d_cmd_ready;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic        mem_cmd_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_start(i_cmd_start), .i_addr(i_addr), .i_cmd_ready(i_cmd_ready),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_cmd_ready(d_cmd_ready),
    .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );

  task automatic clear_inputs();
    i_cmd_start = 1'b0; i_addr = 32'h0;
    d_cmd_start = 1'b0; d_cmd_write = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; d_wmask = 32'h0;
    mem_cmd_ready = 1'b1; mem_rdata = 32'h0; mem_rdata_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one read return, pops the scoreboard and checks the steering.
  task automatic deliver_read();
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL deliver_empty: scoreboard empty when a return was due");
      return;
    end
    e = sb_q.pop_front();
    mem_rdata_valid = 1'b1;
    mem_rdata = e.data;
    #3;
    if ({i_rdata_valid, d_rdata_valid} !== {~e.is_d, e.is_d}) begin
      n_err++;
      $display("FAIL rvalid_steer: got i/d=%b%b want %b%b", i_rdata_valid, d_rdata_valid, ~e.is_d, e.is_d);
    end
    n_vec++;
    if (i_rdata !== e.data || d_rdata !== e.data) begin
      n_err++;
      $display("FAIL rdata: got i=%h d=%h want %h", i_rdata, d_rdata, e.data);
    end
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start} !== 3'b000) begin
      n_err++;
      $display("FAIL wait_quiet: got ir/dr/start=%b want 000", {i_cmd_ready, d_cmd_ready, mem_cmd_start});
    end
    next_cycle();
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    i_cmd_start = 1'b1; i_addr = 32'h10; d_cmd_start = 1'b1; d_cmd_write = 1'b1;
    mem_rdata_valid = 1'b1;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid});
    end
    n_vec++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {ONES, ONES, ONES}) begin
      n_err++;
      $display("FAIL reset_payload: got %h %h %h want all ffffffff", mem_addr, mem_wdata, mem_wmask);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_i_alone();
    clear_inputs();
    i_cmd_start = 1'b1; i_addr = 32'h100;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write} !== 4'b1010) begin
      n_err++;
      $display("FAIL i_alone_ctrl: got %b want 1010", {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write});
    end
    n_vec++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {32'h100, ONES, ONES}) begin
      n_err++;
      $display("FAIL i_alone_payload: got %h %h %h want 00000100 ffffffff ffffffff", mem_addr, mem_wdata, mem_wmask);
    end
    sb_q.push_back({1'b0, 32'hdeadbeef});
    next_cycle();
    i_cmd_start = 1'b0;
    d_cmd_start = 1'b1; d_addr = 32'h44;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_addr} !== {3'b000, ONES}) begin
      n_err++;
      $display("FAIL i_alone_wait: got ir/dr/start=%b addr=%h want 000 ffffffff",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start}, mem_addr);
    end
    next_cycle();
    d_cmd_start = 1'b0;
    deliver_read();
  endtask

  task automatic test_both();
    clear_inputs();
    i_cmd_start = 1'b1; i_addr = 32'h300;
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h200;
    d_wdata = 32'h12; d_wmask = 32'h0000_00ff;
    mem_cmd_ready = 1'b0;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, mem_addr} !== {4'b0011, 32'h200}) begin
      n_err++;
      $display("FAIL both_stall: got %b addr=%h want 0011 00000200",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write}, mem_addr);
    end
    next_cycle();
    mem_cmd_ready = 1'b1;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write} !== 4'b0111) begin
      n_err++;
      $display("FAIL both_d_store: got %b want 0111", {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write});
    end
    n_vec++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {32'h200, 32'h12, 32'h0000_00ff}) begin
      n_err++;
      $display("FAIL both_d_payload: got %h %h %h want 00000200 00000012 000000ff", mem_addr, mem_wdata, mem_wmask);
    end
    next_cycle();
    d_cmd_start = 1'b0; d_cmd_write = 1'b0;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_write, mem_addr} !== {3'b100, 32'h300}) begin
      n_err++;
      $display("FAIL both_i_next: got %b addr=%h want 100 00000300", {i_cmd_ready, d_cmd_ready, mem_cmd_write}, mem_addr);
    end
    sb_q.push_back({1'b0, 32'h0bad_f00d});
    next_cycle();
    i_cmd_start = 1'b0;
    deliver_read();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_rdy;
    clear_inputs();
    i_cmd_start = 1'b1; i_addr = 32'h600;
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h700;
    d_wdata = 32'h55; d_wmask = 32'h0000_ffff;
    for (int k = 0; k <= LIMIT; k++) begin
      #3;
      exp_rdy = (k < LIMIT) ? 2'b01 : 2'b10;
      n_vec++;
      if ({i_cmd_ready, d_cmd_ready} !== exp_rdy) begin
        n_err++;
        $display("FAIL starve_k%0d: got ir/dr=%b want %b", k, {i_cmd_ready, d_cmd_ready}, exp_rdy);
      end
      if (k == LIMIT) sb_q.push_back({1'b0, 32'h0000_6006});
      next_cycle();
    end
    i_cmd_start = 1'b0;
    next_cycle();
    deliver_read();
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_write} !== 3'b011) begin
      n_err++;
      $display("FAIL starve_d_resume: got %b want 011", {i_cmd_ready, d_cmd_ready, mem_cmd_write});
    end
    next_cycle();
  endtask

  task automatic test_d_load_wait();
    clear_inputs();
    d_cmd_start = 1'b1; d_addr = 32'h400;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, mem_addr} !== {4'b0110, 32'h400}) begin
      n_err++;
      $display("FAIL d_load_acc: got %b addr=%h want 0110 00000400",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write}, mem_addr);
    end
    sb_q.push_back({1'b1, 32'hcafe_f00d});
    next_cycle();
    i_cmd_start = 1'b1; i_addr = 32'h800;
    for (int k = 0; k < 3; k++) begin
      mem_cmd_ready = (k != 0);
      #3;
      n_vec++;
      if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid, mem_addr} !==
          {6'b0, ONES}) begin
        n_err++;
        $display("FAIL d_wait_k%0d: got %b addr=%h want 000000 ffffffff", k,
                 {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid}, mem_addr);
      end
      next_cycle();
    end
    i_cmd_start = 1'b0; d_cmd_start = 1'b0;
    deliver_read();
    mem_rdata_valid = 1'b1; mem_rdata = 32'h1111_2222;
    #3;
    n_vec++;
    if ({i_rdata_valid, d_rdata_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_stray_valid: got %b want 00", {i_rdata_valid, d_rdata_valid});
    end
    next_cycle();
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    clear_inputs();
    i_cmd_start = 1'b1; i_addr = 32'h500;
    #3;
    n_vec++;
    if (i_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_acc: got ir=%b want 1", i_cmd_ready);
    end
    sb_q.push_back({1'b0, 32'h0000_5005});
    next_cycle();
    i_cmd_start = 1'b0; d_cmd_start = 1'b1; d_addr = 32'h66;
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_addr} !== {3'b000, ONES}) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b addr=%h want 000 ffffffff",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start}, mem_addr);
    end
    sb_q.delete();
    next_cycle();
    rst_n = 1'b1;
    d_cmd_start = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h1234;
    #3;
    n_vec++;
    if ({i_rdata_valid, d_rdata_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_stray_valid: got %b want 00", {i_rdata_valid, d_rdata_valid});
    end
    next_cycle();
    mem_rdata_valid = 1'b0;
    i_cmd_start = 1'b1; i_addr = 32'h900;
    #3;
    n_vec++;
    if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, mem_addr} !== {4'b1010, 32'h900}) begin
      n_err++;
      $display("FAIL rst_after_i: got %b addr=%h want 1010 00000900",
               {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write}, mem_addr);
    end
    sb_q.push_back({1'b0, 32'h0000_0077});
    next_cycle();
    i_cmd_start = 1'b0;
    deliver_read();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    i_cmd_start = 1'b1; i_addr = 32'ha00;
    #3;
    sb_q.push_back({1'b0, 32'haaaa_0001});
    next_cycle();
    #3;
    n_vec++;
    if (i_cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_wait: got ir=%b want 0", i_cmd_ready);
    end
    next_cycle();
    deliver_read();
    #3;
    n_vec++;
    if ({i_cmd_ready, mem_cmd_start, mem_addr} !== {2'b11, 32'ha00}) begin
      n_err++;
      $display("FAIL b2b_reissue: got ir/start=%b addr=%h want 11 00000a00", {i_cmd_ready, mem_cmd_start}, mem_addr);
    end
    sb_q.push_back({1'b0, 32'haaaa_0002});
    next_cycle();
    i_cmd_start = 1'b0;
    deliver_read();
  endtask

  // Random traffic against an independent model of grant, starvation and memory.
  task automatic test_random();
    logic pi, pd, pw, acc_i, acc_d, dlv, busy, e_gi, e_gd, e_ir, e_dr;
    logic [31:0] pa_i, pa_d, pwd, pwm, e_addr, e_wdata, e_wmask;
    logic [5:0] e_ctrl;
    int starve, lat;
    exp_t e;
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    sb_q.delete();
    starve = 0; busy = 1'b0; lat = 0;
    pi = 1'b0; pd = 1'b0; pw = 1'b0; acc_i = 1'b0; acc_d = 1'b0;
    pa_i = 32'h0; pa_d = 32'h0; pwd = 32'h0; pwm = ONES;
    e.is_d = 1'b0; e.data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!pi || acc_i) begin pi = ($urandom_range(0, 2) != 0); pa_i = $urandom; end
      if (!pd || acc_d) begin
        pd = ($urandom_range(0, 2) != 0); pw = $urandom_range(0, 1);
        pa_d = $urandom; pwd = $urandom;
        case ($urandom_range(0, 2))
          0: pwm = 32'h0000_00ff;
          1: pwm = 32'h0000_ffff;
          default: pwm = ONES;
        endcase
      end
      i_cmd_start = pi; i_addr = pa_i;
      d_cmd_start = pd; d_cmd_write = pw; d_addr = pa_d; d_wdata = pwd; d_wmask = pwm;
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      dlv = busy && (lat == 1);
      if (dlv) begin
        e = sb_q.pop_front();
        mem_rdata_valid = 1'b1; mem_rdata = e.data;
      end else begin
        mem_rdata_valid = 1'b0; mem_rdata = $urandom;
      end
      #3;
      e_gd = !busy && pd && !(pi && starve == LIMIT);
      e_gi = !busy && pi && !e_gd;
      e_ir = e_gi && mem_cmd_ready;
      e_dr = e_gd && mem_cmd_ready;
      e_addr  = e_gd ? pa_d : (e_gi ? pa_i : ONES);
      e_wdata = e_gd ? pwd : ONES;
      e_wmask = e_gd ? pwm : ONES;
      e_ctrl = {e_ir, e_dr, !busy && (pi || pd), e_gd && pw, dlv && !e.is_d, dlv && e.is_d};
      n_vec++;
      if ({i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid} !== e_ctrl) begin
        n_err++;
        $display("FAIL rand_ctrl c%0d: got %b want %b", c,
                 {i_cmd_ready, d_cmd_ready, mem_cmd_start, mem_cmd_write, i_rdata_valid, d_rdata_valid}, e_ctrl);
      end
      n_vec++;
      if ({mem_addr, mem_wdata, mem_wmask} !== {e_addr, e_wdata, e_wmask}) begin
        n_err++;
        $display("FAIL rand_payload c%0d: got %h %h %h want %h %h %h", c,
                 mem_addr, mem_wdata, mem_wmask, e_addr, e_wdata, e_wmask);
      end
      if (dlv) begin
        n_vec++;
        if (i_rdata !== e.data || d_rdata !== e.data) begin
          n_err++;
          $display("FAIL rand_rdata c%0d: got %h %h want %h", c, i_rdata, d_rdata, e.data);
        end
        busy = 1'b0;
      end else if (busy) begin
        lat--;
      end
      acc_i = e_ir;
      acc_d = e_dr;
      if (acc_i) begin
        starve = 0; busy = 1'b1; lat = $urandom_range(1, 3);
        sb_q.push_back({1'b0, pa_i ^ 32'h3c3c_a5a5});
      end
      if (acc_d) begin
        if (pi && starve < LIMIT) starve++;
        if (!pw) begin
          busy = 1'b1; lat = $urandom_range(1, 3);
          sb_q.push_back({1'b1, pa_d ^ 32'h5a5a_c3c3});
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_i_alone();
    test_both();
    test_starvation();
    test_d_load_wait();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
